// File: rtl/vecmul_pkg.sv
// Shared types and default widths for the vector multiplier.
// Holds the sequencer state encoding used by vector_dot_engine.
package vecmul_pkg;

  localparam int DEF_ADDR_WIDTH = 18;
  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_A,
    CAPTURE_A,
    ACCUM,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/vector_dot_engine_dot_mac.sv
// dot_mac: unsigned multiply plus wrapping accumulator.
// Ports: clk, reset, clear, en, a, b in; acc out.
module dot_mac #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  acc
);

  localparam int PW = 2 * DATA_WIDTH;

  logic [PW-1:0] a_ext;
  logic [PW-1:0] b_ext;
  logic [PW-1:0] prod;

  assign a_ext = {{DATA_WIDTH{1'b0}}, a};
  assign b_ext = {{DATA_WIDTH{1'b0}}, b};
  assign prod  = a_ext * b_ext;

  // Sum wraps modulo 2^ACC_WIDTH; no saturation.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_WIDTH'(prod);
    end
  end

endmodule

// File: rtl/vector_dot_engine.sv
// Sequencer in front of block_ram: reads A and B, accumulates the dot
// product, writes it back little-endian. Ports: start/base/len in;
// busy/done/result out; ram_addr/ram_we/ram_wdata out, ram_rdata in.
module vector_dot_engine
  import vecmul_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = 16,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_a,
  input  logic [ADDR_WIDTH-1:0] base_b,
  input  logic [ADDR_WIDTH-1:0] dest_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic [ACC_WIDTH-1:0]  result,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int W  = ACC_WIDTH / DATA_WIDTH;
  localparam int KW = (W > 1) ? $clog2(W) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(W - 1);

  state_t state;
  state_t state_n;

  logic [ADDR_WIDTH-1:0] a_q;
  logic [ADDR_WIDTH-1:0] b_q;
  logic [ADDR_WIDTH-1:0] d_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  idx;
  logic [LEN_WIDTH-1:0]  idx_n;
  logic [KW-1:0]         k;
  logic [DATA_WIDTH-1:0] a_reg;
  logic [ACC_WIDTH-1:0]  acc;
  logic                  accept;
  logic                  last;
  logic                  mac_en;

  assign accept = (state == IDLE) && start;
  assign idx_n  = idx + LEN_WIDTH'(1);
  assign last   = (idx == len_q - LEN_WIDTH'(1));
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

  dot_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .en    (mac_en),
    .a     (a_reg),
    .b     (ram_rdata),
    .acc   (acc)
  );

  // ACCUM issues A[i+1] so the next read overlaps the accumulate.
  always_comb begin
    state_n   = state;
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    mac_en    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = (length == '0) ? WRITE : ISSUE_A;
        end
      end
      ISSUE_A: begin
        ram_addr = a_q + ADDR_WIDTH'(idx);
        state_n  = CAPTURE_A;
      end
      CAPTURE_A: begin
        ram_addr = b_q + ADDR_WIDTH'(idx);
        state_n  = ACCUM;
      end
      ACCUM: begin
        mac_en = 1'b1;
        if (last) begin
          state_n = WRITE;
        end else begin
          ram_addr = a_q + ADDR_WIDTH'(idx_n);
          state_n  = CAPTURE_A;
        end
      end
      WRITE: begin
        ram_we    = 1'b1;
        ram_addr  = d_q + ADDR_WIDTH'(k);
        ram_wdata = acc[int'(k) * DATA_WIDTH +: DATA_WIDTH];
        if (k == K_LAST) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      d_q    <= '0;
      len_q  <= '0;
      idx    <= '0;
      k      <= '0;
      a_reg  <= '0;
      result <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        a_q   <= base_a;
        b_q   <= base_b;
        d_q   <= dest_addr;
        len_q <= length;
        idx   <= '0;
        k     <= '0;
      end
      if (state == CAPTURE_A) begin
        a_reg <= ram_rdata;
      end
      if (state == ACCUM && !last) begin
        idx <= idx_n;
      end
      if (state == WRITE) begin
        if (k == K_LAST) begin
          k      <= '0;
          result <= acc;
        end else begin
          k <= k + KW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_dot_engine.sv
// Bench for vector_dot_engine: 32-bit and 16-bit accumulator instances,
// each with its own registered-read RAM model.
module tb_vector_dot_engine;

  localparam int AW = 18;
  localparam int DW = 8;
  localparam int LW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          start32;
  logic          start16;
  logic [AW-1:0] base_a;
  logic [AW-1:0] base_b;
  logic [AW-1:0] dest_addr;
  logic [LW-1:0] length;

  logic          busy32, done32, we32;
  logic [31:0]   result32;
  logic [AW-1:0] addr32;
  logic [DW-1:0] wdata32, rdata32;

  logic          busy16, done16, we16;
  logic [15:0]   result16;
  logic [AW-1:0] addr16;
  logic [DW-1:0] wdata16, rdata16;

  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;

  logic [DW-1:0] mem32 [0:(1<<AW)-1];
  logic [DW-1:0] mem16 [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  vector_dot_engine #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .ACC_WIDTH(32)
  ) dut32 (
    .clk(clk), .reset(reset), .start(start32),
    .base_a(base_a), .base_b(base_b), .dest_addr(dest_addr),
    .length(length), .busy(busy32), .done(done32), .result(result32),
    .ram_addr(addr32), .ram_we(we32), .ram_wdata(wdata32),
    .ram_rdata(rdata32)
  );

  vector_dot_engine #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .ACC_WIDTH(16)
  ) dut16 (
    .clk(clk), .reset(reset), .start(start16),
    .base_a(base_a), .base_b(base_b), .dest_addr(dest_addr),
    .length(length), .busy(busy16), .done(done16), .result(result16),
    .ram_addr(addr16), .ram_we(we16), .ram_wdata(wdata16),
    .ram_rdata(rdata16)
  );

  // RAM: registered read, read data held on write cycles.
  always @(posedge clk) begin
    if (ld_en) begin
      mem32[ld_addr] <= ld_data;
      mem16[ld_addr] <= ld_data;
    end
    if (we32) mem32[addr32] <= wdata32;
    else      rdata32 <= mem32[addr32];
    if (we16) mem16[addr16] <= wdata16;
    else      rdata16 <= mem16[addr16];
  end

  typedef struct packed {
    bit            wide16;
    logic [AW-1:0] ba;
    logic [AW-1:0] bb;
    logic [AW-1:0] dst;
    int            n;
    logic [31:0]   a;
    logic [31:0]   b;
    logic [31:0]   exp;
  } vec_t;

  vec_t tv[7];

  function automatic vec_t mk(input bit w16, input logic [AW-1:0] ba,
                              input logic [AW-1:0] bb,
                              input logic [AW-1:0] dst, input int n,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp);
    vec_t v;
    v.wide16 = w16; v.ba = ba; v.bb = bb; v.dst = dst;
    v.n = n; v.a = a; v.b = b; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic set_start(input bit w16, input logic val);
    if (w16) start16 = val;
    else     start32 = val;
  endtask

  task automatic run(input vec_t v, input bit stray, input bit rst_mid);
    int w;
    int exp_done;
    int exp_reads;
    int reads;
    int cyc;
    int extra;
    bit seen;
    logic [AW-1:0] ad;
    logic [AW-1:0] ad1;
    logic          s_busy, s_done, s_we;
    logic [AW-1:0] s_addr;
    logic [31:0]   s_res;
    logic [31:0]   want;
    logic [7:0]    m;
    w = v.wide16 ? 2 : 4;
    exp_done = (v.n == 0) ? w + 1 : 2 * v.n + 2 + w;
    exp_reads = (v.n == 0) ? 0 : 2 * v.n + 1;
    ad1 = v.ba + AW'(1);
    for (int j = 0; j < v.n; j++) begin
      ad = v.ba + AW'(j);
      poke(ad, v.a[8*j +: 8]);
      ad = v.bb + AW'(j);
      poke(ad, v.b[8*j +: 8]);
    end
    for (int j = 0; j < w; j++) begin
      ad = v.dst + AW'(j);
      poke(ad, 8'hEE);
    end
    exp_q.push_back(v.exp);
    base_a = v.ba; base_b = v.bb; dest_addr = v.dst; length = LW'(v.n);
    set_start(v.wide16, 1'b1);
    @(negedge clk);
    set_start(v.wide16, 1'b0);
    base_a = ~v.ba; base_b = ~v.bb; dest_addr = ~v.dst; length = 16'd7;
    seen = 0; reads = 0; cyc = 1;
    while (!seen && cyc <= 60) begin
      s_busy = v.wide16 ? busy16 : busy32;
      s_done = v.wide16 ? done16 : done32;
      s_we   = v.wide16 ? we16 : we32;
      s_addr = v.wide16 ? addr16 : addr32;
      s_res  = v.wide16 ? {16'h0, result16} : result32;
      if (cyc == 1) chk("busy_rise", 32'(s_busy), 1);
      if (v.n > 0 && cyc == 1) chk("addr_a0", 32'(s_addr), 32'(v.ba));
      if (v.n > 0 && cyc == 2) chk("addr_b0", 32'(s_addr), 32'(v.bb));
      if (v.n > 1 && cyc == 3) chk("addr_a1", 32'(s_addr), 32'(ad1));
      if (s_busy && !s_we && !s_done) reads++;
      if (stray && cyc == 5) begin
        base_a = 18'h03000; base_b = 18'h03100; length = 16'd1;
        set_start(v.wide16, 1'b1);
      end
      if (stray && cyc == 6) set_start(v.wide16, 1'b0);
      if (rst_mid && cyc == exp_done - w + 1) begin
        chk("we_before_rst", 32'(s_we), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", 32'(busy32), 0);
        chk("rst_done", 32'(done32), 0);
        chk("rst_result", result32, 0);
        chk("rst_we", 32'(we32), 0);
        void'(exp_q.pop_front());
        return;
      end
      if (s_done) begin
        seen = 1;
        chk("done_cycle", 32'(cyc), 32'(exp_done));
        want = exp_q.pop_front();
        chk("result", s_res, want);
        chk("read_cycles", 32'(reads), 32'(exp_reads));
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!seen) begin
      chk("done_timeout", 32'(seen), 1);
      void'(exp_q.pop_front());
    end
    @(negedge clk);
    chk("busy_fall", 32'(v.wide16 ? busy16 : busy32), 0);
    extra = 0;
    for (int j = 0; j < 3; j++) begin
      if (v.wide16 ? done16 : done32) extra++;
      @(negedge clk);
    end
    chk("single_done", 32'(extra), 0);
    for (int j = 0; j < w; j++) begin
      ad = v.dst + AW'(j);
      m = v.wide16 ? mem16[ad] : mem32[ad];
      chk("ram_word", 32'(m), 32'(v.exp[8*j +: 8]));
    end
  endtask

  initial begin
    reset = 1'b1; start32 = 1'b0; start16 = 1'b0;
    base_a = '0; base_b = '0; dest_addr = '0; length = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;

    tv[0] = mk(0, 18'h10, 18'h20, 18'h30, 3, 32'h00030201, 32'h00060504,
               32'd32);
    tv[1] = mk(0, 18'h10, 18'h20, 18'h40, 0, 32'h0, 32'h0, 32'd0);
    tv[2] = mk(1, 18'h50, 18'h60, 18'h70, 2, 32'h0000FFFF, 32'h0000FFFF,
               32'h0000FC02);
    tv[3] = mk(0, 18'h3FFFF, 18'h100, 18'h200, 2, 32'h00000703,
               32'h00000202, 32'd20);
    tv[4] = mk(0, 18'h400, 18'h500, 18'h600, 4, 32'h193264C8, 32'h281E140A,
               32'd6500);
    tv[5] = mk(0, 18'h50, 18'h60, 18'h74, 2, 32'h0000FFFF, 32'h0000FFFF,
               32'h0001FC02);
    tv[6] = mk(1, 18'h10, 18'h20, 18'h78, 0, 32'h0, 32'h0, 32'd0);

    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy32), 0);
    chk("reset_done", 32'(done32), 0);
    chk("reset_result", result32, 0);
    chk("reset_we", 32'(we32), 0);
    chk("reset_addr", 32'(addr32), 0);
    chk("reset_wdata", 32'(wdata32), 0);
    chk("reset_result16", 32'(result16), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run(tv[i], 1'b0, 1'b0);

    run(tv[0], 1'b1, 1'b0);
    run(tv[0], 1'b0, 1'b1);
    run(tv[0], 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
